// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with a valid/ready handshake on both sides.
// Single-cycle logic/arith/shift commands and an iterative shift-add multiplier.
module alu_pipe #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_cmd,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_c,
  output logic             n,
  output logic             z,
  output logic             v,
  output logic             busy
);

  localparam int unsigned SHW      = $clog2(WIDTH);
  localparam int unsigned MUL_ITER = WIDTH / MUL_STEP;
  localparam int unsigned CNTW     = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;

  localparam logic [3:0] CmdMov = 4'b0001;
  localparam logic [3:0] CmdAdd = 4'b0010;
  localparam logic [3:0] CmdAdc = 4'b0011;
  localparam logic [3:0] CmdSub = 4'b0100;
  localparam logic [3:0] CmdSbc = 4'b0101;
  localparam logic [3:0] CmdAnd = 4'b0110;
  localparam logic [3:0] CmdOrr = 4'b0111;
  localparam logic [3:0] CmdEor = 4'b1000;
  localparam logic [3:0] CmdMvn = 4'b1001;
  localparam logic [3:0] CmdMul = 4'b1010;
  localparam logic [3:0] CmdLsl = 4'b1011;
  localparam logic [3:0] CmdLsr = 4'b1100;
  localparam logic [3:0] CmdAsr = 4'b1101;
  localparam logic [3:0] CmdRor = 4'b1110;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              c_q, c_d, n_q, n_d, z_q, z_d, v_q, v_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d, mpr_q, mpr_d, acc_q, acc_d, acc_sum;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              accept, start, upd;

  logic [WIDTH-1:0]         alu_r;
  logic                     alu_c, alu_v;
  logic [WIDTH:0]           sum, lsl_w, lsr_w;
  logic signed [WIDTH:0]    asr_w;
  logic [2*WIDTH-1:0]       ror_w;
  logic [SHW-1:0]           sh;

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StMul);
  assign result    = res_q;
  assign out_c     = c_q;
  assign n         = n_q;
  assign z         = z_q;
  assign v         = v_q;

  // Shifts carry one extra bit on the exit side so C falls out as the last bit shifted away.
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    sum   = '0;
    sh    = in2[SHW-1:0];
    lsl_w = {1'b0, in1} << sh;
    lsr_w = {in1, 1'b0} >> sh;
    asr_w = $signed({in1, 1'b0}) >>> sh;
    ror_w = {in1, in1} >> sh;
    case (alu_cmd)
      CmdMov: alu_r = in2;
      CmdMvn: alu_r = ~in2;
      CmdAnd: alu_r = in1 & in2;
      CmdOrr: alu_r = in1 | in2;
      CmdEor: alu_r = in1 ^ in2;
      CmdAdd, CmdAdc: begin
        sum   = {1'b0, in1} + {1'b0, in2} + {{WIDTH{1'b0}}, alu_cmd[0] & in_c};
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (in1[WIDTH-1] == in2[WIDTH-1]) && (alu_r[WIDTH-1] != in1[WIDTH-1]);
      end
      CmdSub, CmdSbc: begin
        sum   = {1'b0, in1} - {1'b0, in2} - {{WIDTH{1'b0}}, alu_cmd[0] & ~in_c};
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (in1[WIDTH-1] != in2[WIDTH-1]) && (alu_r[WIDTH-1] != in1[WIDTH-1]);
      end
      CmdLsl: begin
        alu_r = lsl_w[WIDTH-1:0];
        alu_c = lsl_w[WIDTH];
      end
      CmdLsr: begin
        alu_r = lsr_w[WIDTH:1];
        alu_c = lsr_w[0];
      end
      CmdAsr: begin
        alu_r = asr_w[WIDTH:1];
        alu_c = asr_w[0];
      end
      CmdRor: begin
        alu_r = ror_w[WIDTH-1:0];
        alu_c = (sh != '0) && ror_w[WIDTH-1];
      end
      default: alu_r = '0;
    endcase
  end

  // One multiplier step: add the shifted multiplicand for each of the next MUL_STEP bits.
  always_comb begin
    acc_sum = acc_q;
    for (int unsigned j = 0; j < MUL_STEP; j++) begin
      if (mpr_q[j]) acc_sum = acc_sum + (mcand_q << j);
    end
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    c_d     = c_q;
    v_d     = v_q;
    mcand_d = mcand_q;
    mpr_d   = mpr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    upd     = 1'b0;
    start   = 1'b0;
    unique case (state_q)
      StIdle: start = accept;
      StMul: begin
        mcand_d = mcand_q << MUL_STEP;
        mpr_d   = mpr_q >> MUL_STEP;
        acc_d   = acc_sum;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNTW'(MUL_ITER - 1)) begin
          state_d = StDone;
          res_d   = acc_sum;
          c_d     = 1'b0;
          v_d     = 1'b0;
          upd     = 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          start   = accept;
        end
      end
      default: state_d = StIdle;
    endcase
    if (start) begin
      if (alu_cmd == CmdMul) begin
        state_d = StMul;
        mcand_d = in1;
        mpr_d   = in2;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        state_d = StDone;
        res_d   = alu_r;
        c_d     = alu_c;
        v_d     = alu_v;
        upd     = 1'b1;
      end
    end
    n_d = upd ? res_d[WIDTH-1] : n_q;
    z_d = upd ? ~|res_d : z_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      res_q   <= '0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      mcand_q <= '0;
      mpr_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      c_q     <= c_d;
      n_q     <= n_d;
      z_q     <= z_d;
      v_q     <= v_d;
      mcand_q <= mcand_d;
      mpr_q   <= mpr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
